// File: rtl/user_irq_ctrl.sv
// user_irq_ctrl: Wishbone-classic slave exposing three rising-edge interrupt
// sources, software trigger and a periodic timer as pending/enable registers,
// driving registered interrupt lines to the management SoC.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone classic controls
//   wbs_sel_i[3:0]            byte-lane enables
//   wbs_adr_i, wbs_dat_i      address, write data
//   wbs_ack_o, wbs_dat_o      single-cycle acknowledge, read data (0 when idle)
//   irq_src_i[2:0]            asynchronous interrupt sources (rising edge)
//   user_irq[2:0]             registered PENDING & ENABLE
//
// Register map (word offsets): 0x00 PENDING (RW1C), 0x04 ENABLE, 0x08 TRIGGER
// (write-only), 0x0C TIMER {TEN[31], RELOAD}, 0x10 COUNT (read-only).
module user_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMER_W   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [2:0]  irq_src_i,
  output logic [2:0]  user_irq
);

  typedef enum logic [5:0] {
    REG_PENDING = 6'h00,
    REG_ENABLE  = 6'h01,
    REG_TRIGGER = 6'h02,
    REG_TIMER   = 6'h03,
    REG_COUNT   = 6'h04
  } reg_e;

  logic [2:0]         sync1_q, sync2_q, hist_q;
  logic [2:0]         pending_q, pending_d;
  logic [2:0]         enable_q, enable_d;
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic               ten_q, ten_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [2:0]         irq_q;

  logic       hit, req, wr;
  reg_e       word;
  logic       wr_pending, wr_enable, wr_trigger, wr_timer;
  logic       tev;
  logic [2:0] src_edge, set_bits, clr_bits;
  logic [31:0] rdata;
  logic       unused_bits;

  // Only bits [31:8] take part in decode; the low byte selects the register.
  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // Gating on ~ack_q gives one ack per request and forbids back-to-back acks.
  assign req  = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr   = req & wbs_we_i;
  assign word = reg_e'(wbs_adr_i[7:2]);

  assign wr_pending = wr & (word == REG_PENDING);
  assign wr_enable  = wr & (word == REG_ENABLE);
  assign wr_trigger = wr & (word == REG_TRIGGER);
  assign wr_timer   = wr & (word == REG_TIMER);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

  assign src_edge = sync2_q & ~hist_q;
  assign tev      = ten_q & (count_q == '0);

  always_comb begin
    set_bits = src_edge | {tev, 2'b00};
    if (wr_trigger && wbs_sel_i[0]) set_bits = set_bits | wbs_dat_i[2:0];
    clr_bits = (wr_pending && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
    // Clear is applied before set so a coincident set wins.
    pending_d = (pending_q & ~clr_bits) | set_bits;
    enable_d  = (wr_enable && wbs_sel_i[0]) ? wbs_dat_i[2:0] : enable_q;
  end

  always_comb begin
    reload_d = reload_q;
    for (int unsigned i = 0; i < TIMER_W; i++) begin
      if (wr_timer && wbs_sel_i[i / 8]) reload_d[i] = wbs_dat_i[i];
    end
    ten_d = (wr_timer && wbs_sel_i[3]) ? wbs_dat_i[31] : ten_q;
    // A TIMER write restarts the period from the freshly written RELOAD.
    count_d = count_q;
    if (wr_timer)      count_d = reload_d;
    else if (ten_q)    count_d = tev ? reload_q : count_q - TIMER_W'(1);
  end

  always_comb begin
    rdata = '0;
    case (word)
      REG_PENDING: rdata[2:0] = pending_q;
      REG_ENABLE:  rdata[2:0] = enable_q;
      REG_TIMER: begin
        rdata[TIMER_W-1:0] = reload_q;
        rdata[31]          = ten_q;
      end
      REG_COUNT:   rdata[TIMER_W-1:0] = count_q;
      default:     rdata = '0;
    endcase
    ack_d = req;
    dat_d = req ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      reload_q  <= '0;
      ten_q     <= 1'b0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= '0;
    end else begin
      sync1_q   <= irq_src_i;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      reload_q  <= reload_d;
      ten_q     <= ten_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= pending_q & enable_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign user_irq  = irq_q;

endmodule

// File: doc/user_irq_ctrl.md
USER_IRQ_CTRL -- requirements
Module: user_irq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address; decode compares wbs_adr_i[31:8] against BASE_ADDR[31:8].
REQ-002 SHALL have parameter TIMER_W, default 16: timer reload and count width, legal range 1..32.
REQ-003 wb_clk_i  in  1  the block's single clock; every flop updates on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-006 wbs_sel_i  in  4  byte-lane enables.
REQ-007 wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
REQ-008 wbs_ack_o  out  1  transfer acknowledge.
REQ-009 wbs_dat_o  out  32  read data.
REQ-010 irq_src_i  in  3  asynchronous interrupt sources, rising-edge sensitive.
REQ-011 user_irq  out  3  registered interrupt lines to the management SoC.

Function
REQ-012 SHALL give each irq_src_i bit a 2-flop synchronizer plus a third history flop; a rising edge is sync2 & ~hist.
REQ-013 SHALL implement the register map at word offsets from the base:
- 0x00 PENDING[2:0]: RW1C.
- 0x04 ENABLE[2:0]: RW.
- 0x08 TRIGGER: write-only, a 1 sets the matching PENDING bit, reads 0.
- 0x0C TIMER: [TIMER_W-1:0] RELOAD, [31] TEN; RW.
- 0x10 COUNT: read-only current timer count.
REQ-014 Within the decoded 256-byte window, unmapped offsets SHALL read 0, ignore writes, and still acknowledge.
REQ-015 SHALL assert wbs_ack_o for exactly one cycle, on the clock after cyc&stb&decode is first seen while ack is low.
- No back-to-back ack; max one transfer per 2 cycles.
- Writes take effect on the acking edge.
- wbs_dat_o is valid while ack=1 and is 0 otherwise.
REQ-016 Outside the decoded window, SHALL never ack and SHALL change no state.
REQ-017 Byte-lane rule: a register byte SHALL be written only when its wbs_sel_i lane is set; bits [2:0] use lane 0, TEN uses lane 3.
REQ-018 PENDING[i] SHALL be set by any of: a detected edge on source i, a TRIGGER write with bit i set, or, for i=2, a timer event.
REQ-019 When a set condition and an RW1C clear hit the same bit in the same cycle, set SHALL win.
REQ-020 user_irq SHALL be a flop loaded each cycle with PENDING & ENABLE, so it lags any change by one cycle.
REQ-021 Source latency: with E0 = the first edge that samples irq_src_i high, PENDING SHALL be set at E2 and user_irq SHALL rise at E3 (if enabled).
REQ-022 A source held high SHALL cause only one set; it re-arms only after it is seen low.
REQ-023 Timer, when TEN=1:
- If COUNT≠0, COUNT decrements by 1 each cycle.
- If COUNT=0, a one-cycle timer event fires and COUNT loads RELOAD.
- Period is RELOAD+1 cycles; RELOAD=0 fires every cycle.
REQ-024 When TEN=0, COUNT SHALL hold and no events SHALL fire.
REQ-025 A write to TIMER SHALL load COUNT with the new RELOAD on the same edge, restarting the period; this takes priority over the decrement and reload.
REQ-026 COUNT SHALL wrap neither below 0 nor above RELOAD.

Reset
REQ-027 While wb_rst_i=1 at a clock edge, SHALL clear PENDING, ENABLE, RELOAD, TEN, COUNT, all synchronizer and history flops, wbs_ack_o, wbs_dat_o and user_irq.
REQ-028 Reset asserted mid-transfer SHALL abort it with no ack; a source high through reset SHALL be treated as an edge at the first post-reset sample.

Verification
REQ-029 Write ENABLE=3'b111, pulse irq_src_i[1] high for 5 cycles -> PENDING=3'b010, user_irq=3'b010 at E3; write PENDING=3'b010 -> user_irq=0 one cycle after ack.
REQ-030 ENABLE=0, write TRIGGER=3'b101 -> PENDING reads 3'b101 and user_irq stays 0; then ENABLE=3'b001 -> user_irq=3'b001.
REQ-031 Write TIMER=32'h8000_0004, ENABLE=3'b100 -> PENDING[2] sets every 5 cycles and the COUNT readback sequence is 4,3,2,1,0,4.
REQ-032 Timer event in the same cycle as a PENDING=3'b100 clear write -> PENDING[2] stays 1.
REQ-033 Read at BASE+0x20 -> ack after 1 cycle, data 0; access at BASE+0x100 -> no ack for 10 cycles and no state change.
REQ-034 Assert wb_rst_i during an active write and while irq_src_i=3'b111 -> no ack, all registers 0; after release, PENDING=3'b111 at E2.
